// File: rtl/ahfp_add_pipe.sv
// ahfp_add_pipe: four-stage pipelined floating-point adder with a valid/ready stream
// interface and a sideband tag that travels with each operation.
//
// Optional feature: define AHFP_ADD_SUB_EN to add the op_sub port (A - B when set).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = !(out_valid && !out_ready)
//   dataa, datab        operands {sign, exponent, mantissa}
//   in_tag              tag captured at acceptance
//   op_sub              subtract select (only with AHFP_ADD_SUB_EN)
//   out_valid/out_ready output handshake
//   result, out_tag     registered sum and its tag
//
// Stages: S1 unpack/classify/swap, S2 align, S3 add/sub, S4 normalise/round/pack.
// Subnormal inputs are flushed to zero; underflowing results flush to signed zero.
module ahfp_add_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  input  logic [TAG_W-1:0]       in_tag,
`ifdef AHFP_ADD_SUB_EN
  input  logic                   op_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  // Working significand: hidden bit, mantissa, guard, round, sticky.
  localparam int unsigned SW  = MAN_W + 4;
  localparam int unsigned LZW = $clog2(SW + 1);
  // Exponent working width: one bit headroom plus a sign bit for underflow.
  localparam int unsigned XW  = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall, adv;
  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  // ---------------- S1: unpack, classify, swap ----------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [W-2:0]     a_mag, b_mag;
  logic             swap, l_sign, eff_sub, special;
  logic [EXP_W-1:0] l_exp, s_exp;
  logic [MAN_W:0]   l_sig, s_sig;
  logic [W-1:0]     spec_val;

  assign a_sign = dataa[W-1];
  assign a_exp  = dataa[W-2:MAN_W];
  assign a_man  = dataa[MAN_W-1:0];
  assign b_exp  = datab[W-2:MAN_W];
  assign b_man  = datab[MAN_W-1:0];
`ifdef AHFP_ADD_SUB_EN
  assign b_sign = datab[W-1] ^ op_sub;
`else
  assign b_sign = datab[W-1];
`endif

  always_comb begin
    a_zero  = (a_exp == '0);
    b_zero  = (b_exp == '0);
    a_inf   = (a_exp == EXP_MAX) && (a_man == '0);
    b_inf   = (b_exp == EXP_MAX) && (b_man == '0);
    a_nan   = (a_exp == EXP_MAX) && (a_man != '0);
    b_nan   = (b_exp == EXP_MAX) && (b_man != '0);
    // Flushed magnitudes; subnormals compare as zero.
    a_mag   = a_zero ? '0 : dataa[W-2:0];
    b_mag   = b_zero ? '0 : datab[W-2:0];
    swap    = (b_mag > a_mag);
    l_sign  = swap ? b_sign : a_sign;
    l_exp   = swap ? b_mag[W-2:MAN_W] : a_mag[W-2:MAN_W];
    s_exp   = swap ? a_mag[W-2:MAN_W] : b_mag[W-2:MAN_W];
    l_sig   = swap ? {!b_zero, b_mag[MAN_W-1:0]} : {!a_zero, a_mag[MAN_W-1:0]};
    s_sig   = swap ? {!a_zero, a_mag[MAN_W-1:0]} : {!b_zero, b_mag[MAN_W-1:0]};
    eff_sub = a_sign ^ b_sign;
    special = a_inf | b_inf | a_nan | b_nan;
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      spec_val = QNAN;
    end else if (a_inf) begin
      spec_val = {a_sign, EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      spec_val = {b_sign, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

  logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_special_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [EXP_W-1:0] s1_exp_q, s1_d_q;
  logic [MAN_W:0]   s1_sig_l_q, s1_sig_s_q;
  logic [W-1:0]     s1_spec_q;

  // ---------------- S2: align smaller significand ----------------
  logic [SW-1:0] s2_ext, s2_shifted, s2_lost_mask, s2_aligned;

  always_comb begin
    s2_ext       = {s1_sig_s_q, 3'b000};
    s2_shifted   = s2_ext >> s1_d_q;
    s2_lost_mask = ~({SW{1'b1}} << s1_d_q);
    if (int'(s1_d_q) >= MAN_W + 3) begin
      // Entire operand lies below the round bit: only stickiness survives.
      s2_aligned = {{(SW-1){1'b0}}, |s1_sig_s_q};
    end else begin
      s2_aligned = {s2_shifted[SW-1:1], s2_shifted[0] | (|(s2_ext & s2_lost_mask))};
    end
  end

  logic             s2_valid_q, s2_sign_q, s2_sub_q, s2_special_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0]    s2_sig_l_q, s2_sig_s_q;
  logic [W-1:0]     s2_spec_q;

  // ---------------- S3: add / subtract ----------------
  // Swap guarantees the larger magnitude is on the left, so subtraction never goes negative.
  logic [SW:0] s3_sum_d;
  assign s3_sum_d = s2_sub_q ? ({1'b0, s2_sig_l_q} - {1'b0, s2_sig_s_q})
                             : ({1'b0, s2_sig_l_q} + {1'b0, s2_sig_s_q});

  logic             s3_valid_q, s3_sign_q, s3_special_q;
  logic [TAG_W-1:0] s3_tag_q;
  logic [EXP_W-1:0] s3_exp_q;
  logic [SW:0]      s3_sum_q;
  logic [W-1:0]     s3_spec_q;

  // ---------------- S4: normalise, round, pack ----------------
  logic [LZW-1:0]   lzc;
  logic             found, round_up;
  logic [SW-1:0]    norm;
  logic [XW-1:0]    exp_x, exp_n, exp_r;
  logic [MAN_W:0]   rnd;
  logic [MAN_W-1:0] man_r;
  logic [W-1:0]     res_d;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (s3_sum_q[i]) found = 1'b1;
        else             lzc   = lzc + {{(LZW-1){1'b0}}, 1'b1};
      end
    end

    exp_x = {2'b00, s3_exp_q};
    if (s3_sum_q[SW]) begin
      // Carry out: shift right one, folding the dropped bit into sticky.
      norm  = {s3_sum_q[SW:2], s3_sum_q[1] | s3_sum_q[0]};
      exp_n = exp_x + {{(XW-1){1'b0}}, 1'b1};
    end else begin
      norm  = s3_sum_q[SW-1:0] << lzc;
      exp_n = exp_x - {{(XW-LZW){1'b0}}, lzc};
    end

    // Nearest-even: guard set and (round|sticky|lsb) set.
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[SW-2:3]} + {{MAN_W{1'b0}}, round_up};
    exp_r    = exp_n + {{(XW-1){1'b0}}, rnd[MAN_W]};
    man_r    = rnd[MAN_W] ? '0 : rnd[MAN_W-1:0];

    if (s3_special_q) begin
      res_d = s3_spec_q;
    end else if (!norm[SW-1]) begin
      // Exact cancellation (or 0 + 0) yields +0.
      res_d = '0;
    end else if (exp_r[XW-1] || (exp_r == '0)) begin
      res_d = {s3_sign_q, {(W-1){1'b0}}};
    end else if (exp_r >= {2'b00, EXP_MAX}) begin
      res_d = {s3_sign_q, EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      res_d = {s3_sign_q, exp_r[EXP_W-1:0], man_r};
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_sub_q     <= 1'b0;
      s1_special_q <= 1'b0;
      s1_tag_q     <= '0;
      s1_exp_q     <= '0;
      s1_d_q       <= '0;
      s1_sig_l_q   <= '0;
      s1_sig_s_q   <= '0;
      s1_spec_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_sub_q     <= 1'b0;
      s2_special_q <= 1'b0;
      s2_tag_q     <= '0;
      s2_exp_q     <= '0;
      s2_sig_l_q   <= '0;
      s2_sig_s_q   <= '0;
      s2_spec_q    <= '0;
      s3_valid_q   <= 1'b0;
      s3_sign_q    <= 1'b0;
      s3_special_q <= 1'b0;
      s3_tag_q     <= '0;
      s3_exp_q     <= '0;
      s3_sum_q     <= '0;
      s3_spec_q    <= '0;
      out_valid    <= 1'b0;
      result       <= '0;
      out_tag      <= '0;
    end else if (adv) begin
      s1_valid_q   <= in_valid;
      s1_sign_q    <= l_sign;
      s1_sub_q     <= eff_sub;
      s1_special_q <= special;
      s1_tag_q     <= in_tag;
      s1_exp_q     <= l_exp;
      s1_d_q       <= l_exp - s_exp;
      s1_sig_l_q   <= l_sig;
      s1_sig_s_q   <= s_sig;
      s1_spec_q    <= spec_val;

      s2_valid_q   <= s1_valid_q;
      s2_sign_q    <= s1_sign_q;
      s2_sub_q     <= s1_sub_q;
      s2_special_q <= s1_special_q;
      s2_tag_q     <= s1_tag_q;
      s2_exp_q     <= s1_exp_q;
      s2_sig_l_q   <= {s1_sig_l_q, 3'b000};
      s2_sig_s_q   <= s2_aligned;
      s2_spec_q    <= s1_spec_q;

      s3_valid_q   <= s2_valid_q;
      s3_sign_q    <= s2_sign_q;
      s3_special_q <= s2_special_q;
      s3_tag_q     <= s2_tag_q;
      s3_exp_q     <= s2_exp_q;
      s3_sum_q     <= s3_sum_d;
      s3_spec_q    <= s2_spec_q;

      out_valid    <= s3_valid_q;
      // Bubbles leave the last result visible rather than loading junk.
      if (s3_valid_q) begin
        result  <= res_d;
        out_tag <= s3_tag_q;
      end
    end
  end

endmodule

// File: doc/ahfp_add_pipe.md
# ahfp_add_pipe

Pipelined, parametrised floating-point adder with a valid/ready stream interface and a sideband tag that travels with each operation. It succeeds the combinational `ahfp_add` in the arithmetic datapath. Each lane of the accumulator and filter blocks instantiates one copy. Format width is generic; the default is IEEE-754 single precision.

## Interface
Parameters:
- `EXP_W`, 8, exponent width in bits.
- `MAN_W`, 23, stored mantissa width in bits (hidden bit excluded).
- `TAG_W`, 4, sideband tag width; the tag is returned unchanged with its result.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands are presented.
- `in_ready` out 1: the block accepts operands this cycle.
- `dataa` in `1+EXP_W+MAN_W`: operand A.
- `datab` in `1+EXP_W+MAN_W`: operand B.
- `in_tag` in `TAG_W`: tag for the operation.
- `op_sub` in 1: subtract B from A. This port exists only with `AHFP_ADD_SUB_EN`.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: downstream consumes the result.
- `result` out `1+EXP_W+MAN_W`: the sum.
- `out_tag` out `TAG_W`: tag of the result.

## Operation
- **Transfers.** Input transfer occurs when `in_valid && in_ready`; output transfer when `out_valid && out_ready`.
- **Pipeline.** Four stages, each with its own valid bit:
  - S1 unpack: classify operands (zero, normal, inf, NaN). Swap so that |A| >= |B|. Compute `d = expA - expB` and the effective operation (signs XOR `op_sub`).
  - S2 align: shift B's significand right by `d`, keeping guard, round and sticky bits. If `d >= MAN_W+3`, B collapses to sticky only.
  - S3 add/sub: operate on `MAN_W+4`-bit significands plus a carry bit.
  - S4 normalise and pack:
    - Leading-zero count, then left shift; or a right shift by 1 on carry.
    - Round to nearest, ties to even. Renormalise if rounding carries out.
    - Pack the result.
- **Stall.** `stall = out_valid && !out_ready`. During a stall all stages hold their state, and `in_ready = !stall`. Bubbles are not collapsed.
- **Zero and subnormal handling.**
  - An exponent field of 0 is treated as zero; subnormal inputs are flushed.
  - A result whose exponent underflows is flushed to zero with the sign of the larger operand.
  - An exact cancellation (x + (-x)) gives +0.
- **Overflow.** Exponent overflow gives infinity with the result sign.
- **Specials.**
  - Any NaN input gives canonical NaN: sign 0, exponent all ones, mantissa MSB 1, remaining bits 0.
  - inf + (-inf) (effective subtract of equal infinities) gives canonical NaN.
  - inf plus a finite value gives that inf.
- **Tag.** `out_tag` equals the `in_tag` captured at acceptance.

## Timing
- **Latency.** Exactly 4 cycles from input transfer to `out_valid`, when no stall intervenes. Each stall cycle adds one cycle.
- **Throughput.** One operation per cycle while `out_ready` stays high.
- **Reset values.** While `reset_n` is low: all stage valids are 0, `out_valid=0`, `result=0`, `out_tag=0`, `in_ready=1`.
- **Reset mid-operation.** All in-flight operations are discarded. No `out_valid` appears for them after release.
- **Simultaneous transfers.** An input transfer and an output transfer in the same cycle are both taken; the pipeline advances.
- **Output stability.** While `out_valid && !out_ready`, `result` and `out_tag` stay stable.
- **No combinational paths.** There is no combinational path from inputs to outputs, except `out_ready` to `in_ready`.

## Configuration
- **`AHFP_ADD_SUB_EN` defined:**
  - The `op_sub` port is present.
  - When `op_sub=1`, B's sign is inverted in S1 and the block computes A - B.
  - `op_sub` is sampled at input transfer.
- **`AHFP_ADD_SUB_EN` undefined:**
  - There is no `op_sub` port; the block always adds.
  - All subtract-selection logic is removed. Effective subtraction still occurs for operands of opposite sign.

## Test plan
- **Reset and latency.**
  - Stimulus: reset, then 3F800000 + 40000000 with tag 5, `out_ready=1`.
  - Response: 40400000 with `out_tag=5` exactly 4 cycles after acceptance. `out_valid=0` during reset.
- **Back-to-back stream.**
  - Stimulus: 43FA0000+41133333, 42FF999A+42FCCCCD, 3F8E363B+3AA137F4 on consecutive cycles.
  - Response: 43FE999A, 437E3334, 3F8E5E89 on consecutive cycles, in order.
- **Backpressure.**
  - Stimulus: the stream above with `out_ready=0` for 3 cycles after the first result.
  - Response: `in_ready=0` and `result` held at 43FE999A for 3 cycles. No result is lost or duplicated.
- **Specials.**
  - 7F800000 + FF800000 gives 7FC00000.
  - 7FC00001 + 3F800000 gives 7FC00000.
  - 7F7FFFFF + 7F7FFFFF gives 7F800000.
  - 00000000 + 3F800000 gives 3F800000.
  - 3F800000 + BF800000 gives 00000000.
- **Subtract (`AHFP_ADD_SUB_EN` defined).**
  - 40400000 - 3F800000 gives 40000000.
  - 3F800000 - 40000000 gives BF800000.
- **Reset mid-flight.**
  - Stimulus: accept 2 operations, then assert `reset_n` low for 1 cycle two cycles later.
  - Response: no `out_valid` afterwards until new input arrives. The first post-reset operation returns after 4 cycles.
